// File: rtl/param_register_bank.sv
// Register file with two combinational read ports, one clocked write port and a
// handshaked dump engine that streams every register as an index/data pair.
module param_register_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] r1,
  input  logic [ADDR_WIDTH-1:0] r2,
  output logic [DATA_WIDTH-1:0] d1,
  output logic [DATA_WIDTH-1:0] d2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reg_write_flag,
  input  logic                  dump_start,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [ADDR_WIDTH-1:0] dump_index,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic                  dump_busy,
  output logic                  dump_done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  logic [DATA_WIDTH-1:0] bank_q [DEPTH];
  logic [DATA_WIDTH-1:0] bank_d [DEPTH];
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  write_en;

  assign write_en = reg_write_flag && !((ZERO_REG != 0) && (write_reg == '0));

  // Read view of a register; with byp set, an in-flight write is visible (write-first).
  function automatic logic [DATA_WIDTH-1:0] view(input logic [ADDR_WIDTH-1:0] a,
                                                 input logic byp);
    if ((ZERO_REG != 0) && (a == '0)) begin
      return '0;
    end
    if (byp && reg_write_flag && (write_reg == a)) begin
      return write_data;
    end
    return bank_q[a];
  endfunction

  always_comb begin
    bank_d = bank_q;
    if (write_en) begin
      bank_d[write_reg] = write_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      bank_q <= bank_d;
    end
  end

  always_comb begin
    d1 = view(r1, BYPASS != 0);
    d2 = view(r2, BYPASS != 0);
  end

  // Dump snapshots always see a same-edge write, independent of the read bypass.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (dump_start) begin
          state_d = SEND;
          idx_d   = '0;
          data_d  = view('0, 1'b1);
        end
      end
      SEND: begin
        if (dump_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            idx_d   = '0;
            data_d  = '0;
          end else begin
            idx_d  = idx_q + ADDR_WIDTH'(1);
            data_d = view(idx_q + ADDR_WIDTH'(1), 1'b1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        data_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  assign dump_valid = (state_q == SEND);
  assign dump_busy  = (state_q != IDLE);
  assign dump_done  = (state_q == DONE);
  assign dump_index = idx_q;
  assign dump_data  = data_q;

endmodule

// File: tb/tb_param_register_bank.sv
// Directed bench: main instance (zero reg + bypass) and an alternate instance
// (neither), dump beats checked against a scoreboard queue.
module tb_param_register_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  r1 = '0, r2 = '0, write_reg = '0;
  logic [31:0] write_data = '0;
  logic        reg_write_flag = 1'b0, dump_start = 1'b0, dump_ready = 1'b0;
  logic [31:0] d1, d2, dump_data;
  logic [4:0]  dump_index;
  logic        dump_valid, dump_busy, dump_done;
  logic [31:0] a_d1, a_d2, a_dump_data;
  logic [4:0]  a_dump_index;
  logic        a_dump_valid, a_dump_busy, a_dump_done;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] dat;
  } beat_t;

  beat_t       sbq[$];
  logic [31:0] model [32];
  int          total = 0;
  int          bad = 0;

  param_register_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .r1(r1), .r2(r2), .d1(d1), .d2(d2),
    .write_reg(write_reg), .write_data(write_data), .reg_write_flag(reg_write_flag),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_index(dump_index), .dump_data(dump_data), .dump_busy(dump_busy),
    .dump_done(dump_done)
  );

  param_register_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0), .BYPASS(0)) alt (
    .clk(clk), .reset(reset), .r1(r1), .r2(r2), .d1(a_d1), .d2(a_d2),
    .write_reg(write_reg), .write_data(write_data), .reg_write_flag(reg_write_flag),
    .dump_start(dump_start), .dump_valid(a_dump_valid), .dump_ready(dump_ready),
    .dump_index(a_dump_index), .dump_data(a_dump_data), .dump_busy(a_dump_busy),
    .dump_done(a_dump_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] v);
    reg_write_flag = 1'b1;
    write_reg      = a;
    write_data     = v;
    tick();
    reg_write_flag = 1'b0;
    if (a != 5'd0) model[a] = v;
  endtask

  task automatic clear_model();
    for (int k = 0; k < 32; k++) model[k] = '0;
  endtask

  // mode 0: ready always high; mode 1: ready 1,0,0 repeating with a write to the
  // stalled index. abort_at >= 0 asserts reset while that beat is presented.
  task automatic run_dump(input int mode, input int abort_at);
    int   cyc = 0;
    int   beats = 0;
    int   dones = 0;
    int   done_cyc = -1;
    logic wrote = 1'b0;
    beat_t b;
    for (int k = 0; k < 32; k++) sbq.push_back('{idx: 5'(k), dat: model[k]});
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    while (cyc < 200) begin
      dump_ready     = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      reg_write_flag = 1'b0;
      if (mode == 1 && !dump_ready && !wrote && beats < 32) begin
        reg_write_flag = 1'b1;
        write_reg      = 5'(beats);
        write_data     = 32'hA5000000 | beats;
        wrote          = 1'b1;
        if (beats != 0) model[beats] = write_data;
      end
      #1;
      if (abort_at >= 0 && dump_valid && beats == abort_at) begin
        reset = 1'b1;
        #1;
        chk("abort_valid", {31'd0, dump_valid}, 32'd0);
        chk("abort_busy", {31'd0, dump_busy}, 32'd0);
        chk("abort_done", {31'd0, dump_done}, 32'd0);
        chk("abort_index", {27'd0, dump_index}, 32'd0);
        chk("abort_data", dump_data, 32'd0);
        sbq.delete();
        clear_model();
        reg_write_flag = 1'b0;
        tick();
        @(negedge clk) reset = 1'b0;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
          tick();
          if (dump_done) dones++;
        end
        chk("abort_no_done", dones, 0);
        r1 = 5'd3; r2 = 5'd5;
        #1;
        chk("abort_reg3", d1, 32'd0);
        chk("abort_reg5", d2, 32'd0);
        return;
      end
      if (dump_valid && dump_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_beat", {27'd0, dump_index}, 32'hFFFFFFFF);
        end else begin
          b = sbq.pop_front();
          chk("beat_index", {27'd0, dump_index}, {27'd0, b.idx});
          chk("beat_data", dump_data, b.dat);
          if (mode == 0) chk("beat_cycle", cyc, beats);
          if (beats == 0) chk("busy_in_send", {31'd0, dump_busy}, 32'd1);
        end
        beats++;
        wrote = 1'b0;
      end
      if (dump_done) begin
        dones++;
        done_cyc = cyc;
      end
      if (dones > 0 && !dump_busy) break;
      tick();
      cyc++;
    end
    reg_write_flag = 1'b0;
    dump_ready     = 1'b0;
    chk("dump_beats", beats, 32);
    chk("done_count", dones, 1);
    // Start edge, then 32 accepting edges: done shows 32 edges after the start edge.
    if (mode == 0) chk("done_cycle", done_cyc, 32);
    chk("queue_empty", sbq.size(), 0);
  endtask

  initial begin
    clear_model();
    #2;
    chk("rst_valid", {31'd0, dump_valid}, 32'd0);
    chk("rst_busy", {31'd0, dump_busy}, 32'd0);
    chk("rst_done", {31'd0, dump_done}, 32'd0);
    chk("rst_index", {27'd0, dump_index}, 32'd0);
    chk("rst_data", dump_data, 32'd0);
    chk("alt_rst_valid", {31'd0, a_dump_valid}, 32'd0);
    #10 reset = 1'b0;
    tick();

    do_write(5'd3, 32'd30);
    do_write(5'd5, 32'd40);
    r1 = 5'd3; r2 = 5'd5;
    #1;
    chk("read_d1_r3", d1, 32'd30);
    chk("read_d2_r5", d2, 32'd40);
    for (int k = 0; k < 32; k++) begin
      r1 = 5'(k); r2 = 5'(31 - k);
      #1;
      chk("sweep_d1", d1, model[k]);
      chk("sweep_d2", d2, model[31 - k]);
    end

    r1 = 5'd0;
    reg_write_flag = 1'b1; write_reg = 5'd0; write_data = 32'hDEADBEEF;
    #1;
    chk("zero_same_cycle", d1, 32'd0);
    chk("alt_zero_pre_edge", a_d1, 32'd0);
    tick();
    reg_write_flag = 1'b0;
    #1;
    chk("zero_after_edge", d1, 32'd0);
    chk("alt_zero_after_edge", a_d1, 32'hDEADBEEF);

    r1 = 5'd7;
    reg_write_flag = 1'b1; write_reg = 5'd7; write_data = 32'd99;
    #1;
    chk("bypass_same_cycle", d1, 32'd99);
    chk("alt_nobypass_same_cycle", a_d1, 32'd0);
    tick();
    reg_write_flag = 1'b0;
    #1;
    chk("bypass_after_edge", d1, 32'd99);
    chk("alt_after_edge", a_d1, 32'd99);
    do_write(5'd7, 32'd0);

    run_dump(0, -1);
    tick();
    run_dump(1, -1);
    r1 = 5'd1;
    #1;
    chk("bp_write_landed", d1, 32'hA5000001);
    tick();

    do_write(5'd3, 32'd30);
    do_write(5'd5, 32'd40);
    run_dump(0, 10);
    do_write(5'd9, 32'h99);
    run_dump(0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
